if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and drives a ready-qualified instruction ROM interface.
- Owns the IF/ID pipeline register (addr, inst, inst_valid) that decode consumes.
- Absorbs downstream stalls through a one-entry skid buffer, so no fetched word is lost or duplicated.

---
 rtl/if_fetch_pkg.sv | 21 ++
 rtl/if_fetch_if.sv | 29 ++
 rtl/if_skid_buf.sv | 39 +++
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and fetch state encoding for the instruction-fetch stage.
// Imported by the fetch top, its skid buffer and the ROM interface.
package if_fetch_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Ready-qualified instruction ROM bus between the fetch stage and the ROM.
// A word transfers only in a cycle with rom_en=1 and rom_ready=1.
interface if_fetch_if
    import if_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int INST_WIDTH = INST_BUS
) ();

    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ready;
    logic [INST_WIDTH-1:0] rom_data;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_ready,
        input  rom_data
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_ready,
        output rom_data
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {addr,inst} holding register for words fetched while decode stalls.
// Priority: flush over load over drain.
module if_skid_buf
    import if_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS,
    parameter int INST_WIDTH = INST_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [INST_WIDTH-1:0] load_inst,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [INST_WIDTH-1:0] inst
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid <= 1'b0;
            addr  <= '0;
            inst  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            addr  <= '0;
            inst  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            inst  <= load_inst;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, ROM request, IF/ID register and stall skid.
// Optional macro IF_BRANCH_REDIRECT_EN adds redirect_en/redirect_addr.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                  ADDR_WIDTH = ADDR_BUS,
    parameter int                  INST_WIDTH = INST_BUS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef IF_BRANCH_REDIRECT_EN
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
`endif
    input  logic                  stall,
    if_fetch_if.master            rom,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid
);

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = RESET_PC & ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] A_ZERO  = ADDR_WIDTH'(ZERO_WORD);
    localparam logic [INST_WIDTH-1:0] I_NOP   = INST_WIDTH'(NOP_INST);

    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  rom_en_q;

    logic                  redir;
    logic [ADDR_WIDTH-1:0] redir_pc;

    logic                  take;
    logic                  skid_load;
    logic                  skid_drain;
    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [INST_WIDTH-1:0] skid_inst;

`ifdef IF_BRANCH_REDIRECT_EN
    assign redir    = redirect_en;
    assign redir_pc = redirect_addr & ~ADDR_WIDTH'(3);
`else
    assign redir    = 1'b0;
    assign redir_pc = PC_INIT;
`endif

    assign take       = (state == S_FETCH) && rom.rom_ready;
    assign skid_load  = take && stall && !redir;
    assign skid_drain = (state == S_HOLD) && !stall && !redir;

    assign rom.rom_en   = rom_en_q;
    assign rom.rom_addr = pc;

    if_skid_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (redir),
        .load_addr (pc),
        .load_inst (rom.rom_data),
        .valid     (skid_valid),
        .addr      (skid_addr),
        .inst      (skid_inst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= S_BOOT;
            pc         <= PC_INIT;
            rom_en_q   <= 1'b0;
            addr       <= A_ZERO;
            inst       <= I_NOP;
            inst_valid <= 1'b0;
        end else if (redir) begin
            // redirect wins over stall and ready; any returned word is dropped
            state      <= S_FETCH;
            pc         <= redir_pc;
            rom_en_q   <= 1'b1;
            addr       <= A_ZERO;
            inst       <= I_NOP;
            inst_valid <= 1'b0;
        end else begin
            unique case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    rom_en_q <= 1'b1;
                end
                S_FETCH: begin
                    unique case (1'b1)
                        rom.rom_ready && !stall: begin
                            addr       <= pc;
                            inst       <= rom.rom_data;
                            inst_valid <= 1'b1;
                            pc         <= pc + STEP;
                        end
                        rom.rom_ready && stall: begin
                            pc       <= pc + STEP;
                            state    <= S_HOLD;
                            rom_en_q <= 1'b0;
                        end
                        !rom.rom_ready && !stall: begin
                            addr       <= A_ZERO;
                            inst       <= I_NOP;
                            inst_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_HOLD: begin
                    if (!stall && skid_valid) begin
                        addr       <= skid_addr;
                        inst       <= skid_inst;
                        inst_valid <= 1'b1;
                        state      <= S_FETCH;
                        rom_en_q   <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_BOOT;
                    rom_en_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: queue-based reference model plus directed literals.
// Also builds with IF_BRANCH_REDIRECT_EN to cover the redirect ports.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic clk;
    logic rst;
    logic rst2;
    logic stall;
    logic rdy;
    logic redir;
    logic [31:0] raddr;

    logic [31:0] addr, inst, addr2, inst2;
    logic        inst_valid, inst_valid2;

    if_fetch_if rom ();
    if_fetch_if rom2 ();

    assign rom.rom_ready  = rdy;
    assign rom.rom_data   = rom.rom_addr ^ PAT;
    assign rom2.rom_ready = 1'b1;
    assign rom2.rom_data  = rom2.rom_addr ^ PAT;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
`ifdef IF_BRANCH_REDIRECT_EN
        .redirect_en   (redir),
        .redirect_addr (raddr),
`endif
        .stall         (stall),
        .rom           (rom.master),
        .addr          (addr),
        .inst          (inst),
        .inst_valid    (inst_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk           (clk),
        .rst           (rst2),
`ifdef IF_BRANCH_REDIRECT_EN
        .redirect_en   (1'b0),
        .redirect_addr (32'h0),
`endif
        .stall         (1'b0),
        .rom           (rom2.master),
        .addr          (addr2),
        .inst          (inst2),
        .inst_valid    (inst_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_chk = 1'b0;

    // Reference model: words accepted from the ROM queue up; decode pops one when not stalled.
    logic [31:0] q[$];
    logic [31:0] m_pc;
    bit          m_boot;
    logic [31:0] e_addr, e_inst;
    logic        e_valid, e_rom_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = 32'h0;
        m_boot   = 1'b1;
        e_addr   = 32'h0;
        e_inst   = 32'h0;
        e_valid  = 1'b0;
        e_rom_en = 1'b0;
    endtask

    task automatic model_update();
        if (redir) begin
            q.delete();
            m_pc    = raddr & ~32'd3;
            m_boot  = 1'b0;
            e_addr  = 32'h0;
            e_inst  = 32'h0;
            e_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            if (e_rom_en && rdy) begin
                q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (!stall) begin
                if (q.size() != 0) begin
                    e_addr  = q.pop_front();
                    e_inst  = e_addr ^ PAT;
                    e_valid = 1'b1;
                end else begin
                    e_addr  = 32'h0;
                    e_inst  = 32'h0;
                    e_valid = 1'b0;
                end
            end
        end
        e_rom_en = !m_boot && (q.size() == 0);
    endtask

    task automatic step(input logic r, input logic s);
        rdy   = r;
        stall = s;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (run_chk) begin
                chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
                chk("addr", addr, e_addr);
                chk("inst", inst, e_inst);
                chk("rom_en", {31'h0, rom.rom_en}, {31'h0, e_rom_en});
                chk("rom_addr", rom.rom_addr, m_pc);
            end
        end
    end

    initial begin
        rst   = 1'b0;
        rst2  = 1'b0;
        rdy   = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        raddr = 32'h0;
        model_reset();
        #2;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_rom_en", {31'h0, rom.rom_en}, 32'h0);
        run_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        step(1'b1, 1'b0);
        chk("boot_valid", {31'h0, inst_valid}, 32'h0);
        chk("boot_rom_en", {31'h0, rom.rom_en}, 32'h1);
        step(1'b1, 1'b0);
        chk("first_addr", addr, 32'h0);
        chk("first_inst", inst, 32'hA5A5_0000);
        chk("wrap_a", addr2, 32'hFFFF_FFF8);
        step(1'b1, 1'b0);
        chk("second_addr", addr, 32'h4);
        chk("wrap_b", addr2, 32'hFFFF_FFFC);
        step(1'b0, 1'b0);
        chk("wrap_c", addr2, 32'h0);
        chk("wrap_c_valid", {31'h0, inst_valid2}, 32'h1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("wait_valid", {31'h0, inst_valid}, 32'h0);
        chk("wait_inst", inst, 32'h0);
        chk("wait_pc", rom.rom_addr, 32'h8);
        step(1'b1, 1'b0);
        chk("after_wait", addr, 32'h8);
        step(1'b1, 1'b1);
        chk("stall_keep", addr, 32'h8);
        chk("hold_rom_en", {31'h0, rom.rom_en}, 32'h0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("hold_keep", addr, 32'h8);
        step(1'b1, 1'b0);
        chk("drain_addr", addr, 32'hC);
        chk("drain_inst", inst, 32'hA5A5_000C);
        step(1'b1, 1'b0);
        chk("post_drain", addr, 32'h10);

        // async reset while the skid is full
        step(1'b1, 1'b1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", {31'h0, inst_valid}, 32'h0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_rom_en", {31'h0, rom.rom_en}, 32'h0);
        chk("arst_pc", rom.rom_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("restart_addr", addr, 32'h0);
        chk("restart_valid", {31'h0, inst_valid}, 32'h1);

`ifdef IF_BRANCH_REDIRECT_EN
        step(1'b1, 1'b1);
        redir = 1'b1;
        raddr = 32'h0000_0102;
        step(1'b1, 1'b1);
        redir = 1'b0;
        chk("redir_bubble", {31'h0, inst_valid}, 32'h0);
        chk("redir_rom_addr", rom.rom_addr, 32'h0000_0100);
        step(1'b1, 1'b0);
        chk("redir_first", addr, 32'h0000_0100);
        chk("redir_inst", inst, 32'hA5A5_0100);
`endif

        for (int i = 0; i < 3000; i++) begin
`ifdef IF_BRANCH_REDIRECT_EN
            redir = ($urandom_range(0, 49) == 0);
            raddr = $urandom;
`endif
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
        end
        redir = 1'b0;
        step(1'b1, 1'b0);
        @(negedge clk);
        run_chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
